// File: rtl/uart_tx_if.sv
// Parallel-side and serial-side signals of the UART transmitter, grouped for
// the transmitter (slave) and whatever feeds it bytes (master).
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  // Handshake: Data_Valid is a one-cycle strobe with no ready signal. A byte is
  // taken on the rising edge where Data_Valid=1 and the transmitter is idle
  // (Busy=0); while Busy=1 any strobe is dropped, so the master must watch Busy.
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESC_W-1:0]    Prescale;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit,
// each held for the latched prescale count. TX_OUT and Busy come straight from flops.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic       CLK,
  input  logic       RST,
  uart_tx_if.slave   bus,
  output logic [2:0] o_dbg_state
);

  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
  localparam int SEL_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [PRESC_W-1:0]    r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic [PRESC_W-1:0]    r_presc;
  logic                  r_tx;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [PRESC_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_load;
  logic                  w_last;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;

  assign w_last = (r_cnt == (r_presc - PRESC_W'(1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_presc   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      if (w_load) begin
        r_data    <= bus.P_DATA;
        r_par_en  <= bus.PAR_EN;
        // Parity is fixed at accept time so the config inputs can wander mid-frame.
        r_par_bit <= (^bus.P_DATA) ^ bus.PAR_TYP;
        r_presc   <= (bus.Prescale == '0) ? PRESC_W'(1) : bus.Prescale;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Data_Valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      S_START: begin
        if (w_last) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + PRESC_W'(1);
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (r_idx == IDX_W'(DATA_WIDTH - 1)) begin
            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + PRESC_W'(1);
        end
      end
      S_PARITY: begin
        if (w_last) begin
          w_state_nxt = S_STOP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + PRESC_W'(1);
        end
      end
      S_STOP: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + PRESC_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so it lands in r_tx on the same edge.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b1;
    case (w_state_nxt)
      S_IDLE:   w_busy_nxt = 1'b0;
      S_START:  w_tx_nxt   = 1'b0;
      S_DATA:   w_tx_nxt   = r_data[w_idx_nxt[SEL_W-1:0]];
      S_PARITY: w_tx_nxt   = r_par_bit;
      S_STOP:   w_tx_nxt   = 1'b1;
      default: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign bus.TX_OUT  = r_tx;
  assign bus.Busy    = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of hand-computed frames plus sequences for
// ignored strobes, back-to-back frames and mid-frame reset.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  uart_tx_if #(.DATA_WIDTH(8), .PRESC_W(6)) bus ();

  uart_tx #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .CLK         (clk),
    .RST         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seq holds the expected line levels in transmit order, left to right
  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_typ;
    logic [5:0]  presc;
    logic [0:15] seq;
    int          nbits;
    int          pl;
  } vec_t;

  vec_t vecs[7];

  task automatic check1(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // driver: present a byte at negedge, let one rising edge take it
  task automatic drive_accept(input logic [7:0] data, input logic pe, input logic pt,
                              input logic [5:0] presc, input bit hold);
    @(negedge clk);
    bus.P_DATA     = data;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Prescale   = presc;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.Data_Valid = 1'b0;
  endtask

  // Called #1 after the accept edge; checks every cycle of the frame, then idle.
  task automatic check_frame(input string name, input logic [0:15] seq, input int nbits,
                             input int pl, input int inj);
    int   s;
    bit   bad;
    logic gtx;
    logic gbusy;
    s = 0;
    for (int j = 0; j < nbits; j++) begin
      bad = 0; gtx = 1'b0; gbusy = 1'b0;
      for (int c = 0; c < pl; c++) begin
        if (s == inj) begin
          bus.P_DATA     = 8'h3C;
          bus.PAR_EN     = 1'b1;
          bus.PAR_TYP    = 1'b1;
          bus.Prescale   = 6'd3;
          bus.Data_Valid = 1'b1;
        end else if (inj >= 0 && s == inj + 1) begin
          bus.Data_Valid = 1'b0;
        end
        if (!bad && (bus.TX_OUT !== seq[j] || bus.Busy !== 1'b1)) begin
          bad = 1; gtx = bus.TX_OUT; gbusy = bus.Busy;
        end
        s++;
        @(posedge clk);
        #1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit%0d got tx=%b busy=%b expected tx=%b busy=1",
                 name, j, gtx, gbusy, seq[j]);
      end
    end
    checks++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL %s end got tx=%b busy=%b state=%0d expected tx=1 busy=0 state=0",
               name, bus.TX_OUT, bus.Busy, dbg_state);
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8, 16'b0101001011_000000, 10, 8};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'd8, 16'b01010010101_00000, 11, 8};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 6'd8, 16'b01010010111_00000, 11, 8};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 6'd1, 16'b01110000011_00000, 11, 1};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 6'd0, 16'b0111111111_000000, 10, 1};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 6'd3, 16'b00011110011_00000, 11, 3};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 6'd2, 16'b01000000011_00000, 11, 2};

    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = '0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_tx",    {7'd0, bus.TX_OUT}, 8'd1);
    check1("reset_busy",  {7'd0, bus.Busy},   8'd0);
    check1("reset_state", {5'd0, dbg_state},  8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("idle_tx", {7'd0, bus.TX_OUT}, 8'd1);

    for (int i = 0; i < 7; i++) begin
      drive_accept(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].presc, 1'b0);
      check_frame($sformatf("vec%0d", i), vecs[i].seq, vecs[i].nbits, vecs[i].pl, -1);
    end

    // strobe with different byte/config at cycle 20 must not disturb the 0xA5 frame
    drive_accept(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
    check_frame("ignore", vecs[0].seq, 10, 8, 20);
    repeat (2) @(posedge clk);
    #1;
    check1("ignore_idle", {7'd0, bus.Busy}, 8'd0);

    // Data_Valid held high: 0x55 then 0xAA with a single idle cycle between
    drive_accept(8'h55, 1'b0, 1'b0, 6'd2, 1'b1);
    bus.P_DATA = 8'hAA;
    check_frame("b2b_first", 16'b0101010101_000000, 10, 2, -1);
    @(posedge clk);
    #1;
    bus.Data_Valid = 1'b0;
    check_frame("b2b_second", 16'b0010101011_000000, 10, 2, -1);

    // reset during data bit 3 of 0xA5 (a 0 on the line)
    drive_accept(8'hA5, 1'b0, 1'b0, 6'd4, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    check1("pre_rst_tx", {7'd0, bus.TX_OUT}, 8'd0);
    rst = 1'b1;
    #1;
    check1("mid_rst_tx",    {7'd0, bus.TX_OUT}, 8'd1);
    check1("mid_rst_busy",  {7'd0, bus.Busy},   8'd0);
    check1("mid_rst_state", {5'd0, dbg_state},  8'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_accept(8'h07, 1'b1, 1'b0, 6'd1, 1'b0);
    check_frame("post_rst", vecs[3].seq, 11, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
